// File: rtl/jk_pkg.sv
// Shared defaults and JK excitation codes for the up/down counter slice.
package jk_pkg;
    localparam int WIDTH_DEF   = 4;
    localparam int MODULUS_DEF = 10;

    // {J,K} excitation codes
    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] RESET  = 2'b01;
    localparam logic [1:0] SET    = 2'b10;
    localparam logic [1:0] TOGGLE = 2'b11;
endpackage

// File: rtl/jk_updown_counter_jkff.sv
// Single JK flip-flop with asynchronous active-high reset.
module jkff
    import jk_pkg::*;
(
    input  logic j,
    input  logic k,
    input  logic clk,
    input  logic rst,
    output logic q,
    output logic qbar
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                HOLD:    q <= q;
                RESET:   q <= 1'b0;
                SET:     q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    assign qbar = ~q;
endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-N up/down counter built on a JK flip-flop bank; this block only
// computes per-bit J/K excitation, the terminal-count decode and the wrap pulse.
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MODULUS = MODULUS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH:0]   MOD  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] qbar, jv, kv, din_eff, inc, dec, tgl;
    logic             is_zero, legal;

    assign is_zero = &qbar;
    assign legal   = ({1'b0, q} < MOD);
    assign din_eff = ({1'b0, din} < MOD) ? din : MAXV;
    assign inc     = q + 1'b1;
    assign dec     = q - 1'b1;

    // Ordinary steps toggle only the changing bits; wraps, loads and illegal
    // recovery drive an explicit set/reset target instead.
    always_comb begin
        jv  = '0;
        kv  = '0;
        tgl = '0;
        if (load) begin
            jv = din_eff;
            kv = ~din_eff;
        end else if (en) begin
            if (!legal) begin
                kv = '1;
            end else if (up) begin
                if (q == MAXV) begin
                    kv = '1;
                end else begin
                    tgl = q ^ inc;
                    jv  = tgl;
                    kv  = tgl;
                end
            end else begin
                if (is_zero) begin
                    jv = MAXV;
                    kv = ~MAXV;
                end else begin
                    tgl = q ^ dec;
                    jv  = tgl;
                    kv  = tgl;
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jkff u_ff (
            .j    (jv[i]),
            .k    (kv[i]),
            .clk  (clk),
            .rst  (rst),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    // rst gating keeps tc low while the bank is being held at zero
    assign tc = ~rst & en & ~load & ((up & (q == MAXV)) | (~up & is_zero));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap <= 1'b0;
        else     wrap <= tc;
    end
endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed and randomised checks of the modulo-10 JK up/down counter.
module tb_jk_updown_counter;
    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] din;
    logic [3:0] q;
    logic       tc, wrap;

    int n_cmp = 0;
    int n_err = 0;

    jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .q    (q),
        .tc   (tc),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model_next(logic [3:0] cq, logic cen, logic cup,
                                              logic cload, logic [3:0] cdin);
        if (cload)     return (cdin < 4'd10) ? cdin : 4'd9;
        else if (cen)  return cup ? ((cq == 4'd9) ? 4'd0 : cq + 4'd1)
                                  : ((cq == 4'd0) ? 4'd9 : cq - 4'd1);
        else           return cq;
    endfunction

    initial begin
        logic [3:0] qm;
        logic       wm, tcm;
        int         tc_edges, wrap_seen;

        // reset state, tc forced low even with en=1 up=0 and q=0
        rst = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; din = '0;
        #3;
        chk("rst_q", q, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_tc", tc, 0);

        // reach q=7, then async reset mid-count
        rst = 1'b0; en = 1'b0; load = 1'b1; din = 4'd7;
        step();
        chk("load7_q", q, 7);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", q, 0);
        chk("async_rst_wrap", wrap, 0);
        chk("async_rst_tc", tc, 0);
        rst = 1'b0; en = 1'b0;

        // up wrap
        load = 1'b1; din = 4'd8;
        step();
        chk("upw_load_q", q, 8);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1 chk("upw_tc8", tc, 0);
        step();
        chk("upw_q9", q, 9);
        chk("upw_tc9", tc, 1);
        chk("upw_wrap_pre", wrap, 0);
        step();
        chk("upw_q0", q, 0);
        chk("upw_wrap", wrap, 1);
        chk("upw_tc0", tc, 0);
        step();
        chk("upw_q1", q, 1);
        chk("upw_wrap_end", wrap, 0);

        // down wrap
        en = 1'b0; load = 1'b1; din = 4'd1;
        step();
        chk("dnw_load_q", q, 1);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        chk("dnw_q0", q, 0);
        chk("dnw_tc0", tc, 1);
        step();
        chk("dnw_q9", q, 9);
        chk("dnw_wrap", wrap, 1);
        step();
        chk("dnw_q8", q, 8);
        chk("dnw_wrap_end", wrap, 0);

        // load priority and clamp
        en = 1'b0; load = 1'b1; din = 4'd0;
        step();
        chk("ld0_q", q, 0);
        en = 1'b1; up = 1'b0; din = 4'd13;
        #1 chk("ld_tc_masked", tc, 0);
        step();
        chk("ld13_clamp_q", q, 9);
        chk("ld13_wrap", wrap, 0);
        din = 4'd3;
        step();
        chk("ld3_q", q, 3);
        din = 4'd10;
        step();
        chk("ld10_clamp_q", q, 9);

        // hold then direction flips
        din = 4'd4;
        step();
        chk("ld4_q", q, 4);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_q", q, 4);
        end
        en = 1'b1; up = 1'b1;
        step(); chk("flip_up_q", q, 5);
        up = 1'b0;
        step(); chk("flip_dn_q", q, 4);
        up = 1'b1;
        step(); chk("flip_up2_q", q, 5);

        // randomised run against the reference model
        qm = 4'd5; wm = 1'b0; tc_edges = 0; wrap_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) == 1;
            load = ($urandom_range(0, 9) == 0);
            din  = 4'($urandom_range(0, 15));
            #1;
            tcm = en & ~load & ((up & (qm == 4'd9)) | (~up & (qm == 4'd0)));
            chk("rnd_tc", tc, tcm);
            if (tc) tc_edges++;
            qm = model_next(qm, en, up, load, din);
            wm = tcm;
            step();
            chk("rnd_q", q, qm);
            chk("rnd_wrap", wrap, wm);
            chk("rnd_q_range", (q < 4'd10), 1);
            if (wrap) wrap_seen++;
        end
        chk("rnd_wrap_count", wrap_seen, tc_edges);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jk_updown_counter.md
JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 10, giving the count range 0..MODULUS-1, with 2 <= MODULUS <= 2**WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have port din, input, WIDTH bits: the load value.
REQ-009 The block SHALL have port q, output, WIDTH bits: the current count, taken directly from the flip-flop bank.
REQ-010 The block SHALL have port tc, output, 1 bit: combinational terminal count.
REQ-011 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse after each wrap.

Function
REQ-012 State SHALL be held in WIDTH JK flip-flops; this block SHALL compute each bit's J/K excitation only.
REQ-013 Priority per edge SHALL be: rst > load > en > hold.
REQ-014 On load, bit i SHALL receive J=din_eff[i], K=~din_eff[i], so that q=din_eff one cycle later, regardless of en or up.
REQ-015 din_eff SHALL be din when din < MODULUS, else MODULUS-1 (clamp).
REQ-016 On hold (load=0, en=0), every bit SHALL receive J=0, K=0, and q SHALL be unchanged.
REQ-017 On an up count with q < MODULUS-1, q SHALL become q+1 next cycle; with q = MODULUS-1, q SHALL become 0.
REQ-018 On a down count with q > 0, q SHALL become q-1 next cycle; with q = 0, q SHALL become MODULUS-1.
REQ-019 Count excitation SHALL be J=K=1 for bits that toggle; non-toggling bits SHALL get J=K=0.
REQ-020 Wrap targets SHALL use a J/K set/reset pattern (J=target bit, K=~target bit), not toggles.
REQ-021 tc SHALL be en & ~load & ((up & q==MODULUS-1) | (~up & q==0)).
REQ-022 wrap SHALL be high for exactly one cycle, in the cycle after an edge where tc was high, and SHALL be low otherwise.
REQ-023 A direction change SHALL take effect on the same edge: up is sampled each edge with no pipeline.
REQ-024 If q holds an illegal value (>= MODULUS, reachable only through a fault), the next count edge SHALL force q=0.
REQ-025 No combinational path SHALL exist from inputs to q; tc is the only combinational output.

Reset
REQ-026 While rst=1, the outputs SHALL be q=0, wrap=0, and tc=0, asynchronously, independent of clk.
REQ-027 Reset asserted mid-count SHALL clear state immediately, with no wrap pulse generated.
REQ-028 The first edge after rst deasserts SHALL act normally per REQ-013.

Structure
REQ-029 A shared package jk_pkg SHALL hold the WIDTH and MODULUS defaults and the localparams for JK excitation codes: HOLD=00, RESET=01, SET=10, TOGGLE=11.
REQ-030 The flip-flop bank SHALL be WIDTH instances of the team's existing jkff sub-module (ports j, k, clk, rst, q, qbar), built with a generate loop.
REQ-031 The remaining logic SHALL be the excitation logic, the tc decode, and one wrap register; the target size is 120-250 lines of RTL.

Verification
REQ-032 Reset: with rst=1 from q=7, en=1 -> q=0, wrap=0, and tc=0 within the same timestep, before the next clk edge.
REQ-033 Up wrap (MODULUS=10): load 8, then en=1, up=1 for 3 edges -> q=9 (tc=1), then q=0 (wrap=1 the following cycle), then q=1.
REQ-034 Down wrap: load 1, then en=1, up=0 for 3 edges -> q=0 (tc=1), then q=9 (wrap pulse), then q=8.
REQ-035 Load priority and clamp: load=1, en=1, din=13 -> q=9 next edge, with no count applied and tc=0 during load.
REQ-036 Hold and direction flip: from q=4, en=0 for 5 edges -> q stays 4; then en=1 with up alternating 1,0,1 -> q=5,4,5.
REQ-037 Randomised en/up/load/din stimulus for 1000 cycles -> q matches a reference model every cycle, q < MODULUS, and wrap count equals the number of tc-high edges.
